// File: rtl/fft_reorder_pp_if.sv
// ---------------------------------------------------------------------------
// fft_reorder_pp_if
// Streaming bus bundle for the FFT output reorder buffer.
//
// Signals
//   in_valid  : upstream sample valid
//   in_data   : upstream sample (arrives in bit-reversed index order)
//   in_ready  : reorder buffer can accept in_data
//   mode      : 0 = bit-reverse reorder, 1 = pass-through (sampled per frame)
//   out_valid : out_data valid
//   out_data  : reordered output sample
//   out_ready : downstream accepts out_data
//   out_sof   : first sample of an output frame (qualified by out_valid)
//   out_eof   : last sample of an output frame (qualified by out_valid)
//
// Modports
//   master : the side that produces input samples and consumes output samples
//   slave  : the reorder buffer itself
// ---------------------------------------------------------------------------
interface fft_reorder_pp_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mode;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          out_sof;
  logic          out_eof;

  modport master (
    output in_valid,
    output in_data,
    output mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sof,
    input  out_eof
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sof,
    output out_eof
  );
endinterface

// File: rtl/fft_reorder_pp.sv
// ---------------------------------------------------------------------------
// fft_reorder_pp
// Ping-pong reorder buffer placed after a pipelined FFT. Frames of N = 2**LOG2N
// samples arrive in bit-reversed index order. Each frame is written linearly
// into one of two banks and, once complete, is read back in natural order
// (address = bitrev(read count)) or, in pass-through mode, linearly.
// While one bank drains, the other fills, giving one sample per cycle.
//
// Parameters
//   LOG2N : log2 of frame length (2..10)
//   DW    : sample width, treated as opaque data
//
// Ports
//   clk   : clock, rising edge
//   nrst  : synchronous active-low reset (clears flags/counters, not banks)
//   bus   : fft_reorder_pp_if.slave (input stream, output stream, mode)
//   frame_cnt : 16-bit count of completed output frames, present only when
//               the macro FFT_REORDER_FRAME_CNT_EN is defined
//
// All handshake outputs are flops loaded from next-state values, so in_ready
// has no combinational path from out_ready.
// ---------------------------------------------------------------------------
module fft_reorder_pp #(
  parameter int LOG2N = 5,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 nrst,
  fft_reorder_pp_if.slave      bus
`ifdef FFT_REORDER_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_ZERO = {LOG2N{1'b0}};
  localparam logic [LOG2N-1:0] CNT_ONE  = {{(LOG2N-1){1'b0}}, 1'b1};
  localparam logic [LOG2N-1:0] CNT_LAST = {LOG2N{1'b1}};

  // Reverse the bit order of a sample index.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  // Sample storage: two banks of N entries, never reset.
  logic [DW-1:0]    mem_q [0:1][0:N-1];

  logic [1:0]       full_q,    full_d;
  logic [1:0]       mode_q,    mode_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_cnt_q,  wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q,  rd_cnt_d;

  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_sof_q;
  logic             out_eof_q;
  logic [DW-1:0]    out_data_q;

  logic             in_xfer_s;
  logic             out_xfer_s;
  logic [LOG2N-1:0] rd_addr_s;

  assign in_xfer_s  = bus.in_valid && in_ready_q;
  assign out_xfer_s = out_valid_q && bus.out_ready;

  // Next-state computation for flags, bank pointers, counters and stored modes.
  always_comb begin
    full_d    = full_q;
    mode_d    = mode_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;

    if (in_xfer_s) begin
      wr_cnt_d = wr_cnt_q + CNT_ONE;
      // Mode is latched only with the first sample of a frame.
      if (wr_cnt_q == CNT_ZERO) begin
        mode_d[wr_bank_q] = bus.mode;
      end else begin
        mode_d = mode_q;
      end
      if (wr_cnt_q == CNT_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_bank_d = wr_bank_q;
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end

    // A read only happens from a full bank and a write only into a non-full
    // bank, so a simultaneous last-write and last-read touch different flags.
    if (out_xfer_s) begin
      rd_cnt_d = rd_cnt_q + CNT_ONE;
      if (rd_cnt_q == CNT_LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_bank_d = rd_bank_q;
      end
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
  end

  // Read address for the sample that will be presented next cycle.
  always_comb begin
    if (mode_d[rd_bank_d]) begin
      rd_addr_s = rd_cnt_d;
    end else begin
      rd_addr_s = bitrev(rd_cnt_d);
    end
  end

  // Control state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      full_q      <= 2'b00;
      mode_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= CNT_ZERO;
      rd_cnt_q    <= CNT_ZERO;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      full_q      <= full_d;
      mode_q      <= mode_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      in_ready_q  <= ~full_d[wr_bank_d];
      out_valid_q <= full_d[rd_bank_d];
      out_sof_q   <= full_d[rd_bank_d] && (rd_cnt_d == CNT_ZERO);
      out_eof_q   <= full_d[rd_bank_d] && (rd_cnt_d == CNT_LAST);
    end
  end

  // Bank writes and output data register. The output register reloads every
  // cycle from the next read address; the entry it reads is never the one
  // being written in the same cycle (a bank being filled is only read at
  // index 0, which is written first), so no write bypass is needed.
  always_ff @(posedge clk) begin
    if (nrst && in_xfer_s) begin
      mem_q[wr_bank_q][wr_cnt_q] <= bus.in_data;
    end
    out_data_q <= mem_q[rd_bank_d][rd_addr_s];
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;
  assign bus.out_data  = out_data_q;

`ifdef FFT_REORDER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Completed output frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      frame_cnt_q <= 16'd0;
    end else if (out_xfer_s && out_eof_q) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_q <= frame_cnt_q;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
